image_window_gen: RTL and testbench

IMAGE_WINDOW_GEN -- requirements
Module: image_window_gen

---
 rtl/image_window_gen_if.sv | 28 ++
 rtl/image_window_gen.sv | 138 +++++++++++++
 tb/tb_image_window_gen.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/image_window_gen_if.sv
// Window generator bus: scan control, pixel-memory read port and window output handshake.
// master = generator side, slave = memory/consumer side.
interface image_window_gen_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 18,
    parameter int WIN_N  = 27
);
    logic                      start;
    logic                      mem_rd;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_rdata;
    logic [WIN_N*DATA_W-1:0]   win_data;
    logic                      win_valid;
    logic                      win_ready;
    logic [15:0]               win_row;
    logic [15:0]               win_col;
    logic                      busy;
    logic                      done;

    modport master (
        input  start, mem_rdata, win_ready,
        output mem_rd, mem_addr, win_data, win_valid, win_row, win_col, busy, done
    );
    modport slave (
        output start, mem_rdata, win_ready,
        input  mem_rd, mem_addr, win_data, win_valid, win_row, win_col, busy, done
    );
endinterface

// File: rtl/image_window_gen.sv
// Sliding KxK window generator over a CH-plane image: fetches one window from pixel memory
// word by word, presents it on a valid/ready port, then steps by STRIDE until the image is covered.
module image_window_gen #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 224,
    parameter int CH     = 3,
    parameter int K      = 3,
    parameter int STRIDE = 2,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    image_window_gen_if.master bus
);
    localparam int N     = K * K * CH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam bit DEGEN = (K > IMG_W) || (K > IMG_H);

    localparam logic [IDX_W-1:0]  NM1     = IDX_W'(N - 1);
    localparam logic [15:0]       KM1     = 16'(K - 1);
    localparam logic [15:0]       CHM1    = 16'(CH - 1);
    localparam logic [ADDR_W-1:0] PLANE_A = ADDR_W'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] IMGW_A  = ADDR_W'(IMG_W);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, FIN} state_t;

    state_t                   r_state, w_next;
    logic [15:0]              r_row0, r_col0;
    logic [15:0]              r_c, r_kr, r_kc;
    logic [IDX_W-1:0]         r_idx, r_idx_d;
    logic                     r_rd_d;
    logic [N-1:0][DATA_W-1:0] r_win;

    logic                     w_rd, w_hs, w_last_rd, w_col_wrap, w_row_end;
    logic [ADDR_W-1:0]        w_addr;

    assign w_last_rd  = (r_idx == NM1);
    assign w_hs       = (r_state == OUT) && bus.win_ready;
    assign w_col_wrap = (32'(r_col0) + STRIDE + K) > IMG_W;
    assign w_row_end  = (32'(r_row0) + STRIDE + K) > IMG_H;

    // Full-width address math so large planes never truncate below ADDR_W.
    assign w_addr = ADDR_W'(r_c) * PLANE_A
                  + (ADDR_W'(r_row0) + ADDR_W'(r_kr)) * IMGW_A
                  + ADDR_W'(r_col0) + ADDR_W'(r_kc);

    assign bus.mem_addr = w_addr;
    assign bus.win_data = r_win;
    assign bus.win_row  = r_row0;
    assign bus.win_col  = r_col0;

    always_comb begin
        w_next        = r_state;
        w_rd          = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.win_valid = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (r_state)
            IDLE:  if (bus.start) w_next = FETCH;
            FETCH: begin
                bus.busy = 1'b1;
                // A window that cannot fit anywhere: spend one cycle here, then finish.
                if (DEGEN) w_next = FIN;
                else begin
                    w_rd = 1'b1;
                    if (w_last_rd) w_next = DRAIN;
                end
            end
            DRAIN: begin
                bus.busy = 1'b1;
                if (r_rd_d) w_next = OUT;
            end
            OUT: begin
                bus.busy      = 1'b1;
                bus.win_valid = 1'b1;
                if (bus.win_ready) w_next = (w_col_wrap && w_row_end) ? FIN : FETCH;
            end
            FIN: begin
                bus.done = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
        bus.mem_rd = w_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_row0  <= '0;
            r_col0  <= '0;
            r_c     <= '0;
            r_kr    <= '0;
            r_kc    <= '0;
            r_idx   <= '0;
            r_idx_d <= '0;
            r_rd_d  <= 1'b0;
            r_win   <= '0;
        end else begin
            r_state <= w_next;
            r_rd_d  <= w_rd;
            r_idx_d <= r_idx;
            // Read data lands one cycle after its strobe; slot = fetch order index.
            if (r_rd_d) r_win[r_idx_d] <= bus.mem_rdata;

            if (r_state == IDLE && bus.start) begin
                r_row0 <= '0;
                r_col0 <= '0;
            end

            if (w_rd) begin
                r_idx <= w_last_rd ? '0 : r_idx + 1'b1;
                if (r_kc == KM1) begin
                    r_kc <= '0;
                    if (r_kr == KM1) begin
                        r_kr <= '0;
                        r_c  <= (r_c == CHM1) ? '0 : r_c + 16'd1;
                    end else begin
                        r_kr <= r_kr + 16'd1;
                    end
                end else begin
                    r_kc <= r_kc + 16'd1;
                end
            end

            if (w_hs) begin
                if (w_col_wrap) begin
                    r_col0 <= '0;
                    if (!w_row_end) r_row0 <= r_row0 + 16'(STRIDE);
                end else begin
                    r_col0 <= r_col0 + 16'(STRIDE);
                end
            end
        end
    end
endmodule

// File: tb/tb_image_window_gen.sv
// Bench for image_window_gen: 6x5x2 image, K=3, STRIDE=2, memory word = its address,
// scoreboard built from a window list plus a degenerate K=7 instance.
module tb_image_window_gen;
    localparam int DW = 16, AW = 18;
    localparam int IMG_W = 6, IMG_H = 5, CH = 2, K = 3, STRIDE = 2;
    localparam int N = K * K * CH;
    localparam int DK = 7, DN = DK * DK * CH;

    logic clk, rst;
    int   cyc = 0;
    int   tests = 0, fails = 0;
    int   done_cnt = 0, acc_cnt = 0, stall_cnt = 0;
    int   rmode = 0;
    int   wr[$], wc[$];
    int   lit00 [N] = '{0, 1, 2, 6, 7, 8, 12, 13, 14, 30, 31, 32, 36, 37, 38, 42, 43, 44};
    logic [N*DW-1:0] lit_v, tmp_v;

    image_window_gen_if #(.DATA_W(DW), .ADDR_W(AW), .WIN_N(N))  bus ();
    image_window_gen_if #(.DATA_W(DW), .ADDR_W(AW), .WIN_N(DN)) dbus ();

    image_window_gen #(.DATA_W(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .K(K),
                       .STRIDE(STRIDE), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
    image_window_gen #(.DATA_W(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .K(DK),
                       .STRIDE(STRIDE), .ADDR_W(AW)) dut_deg (.clk(clk), .rst(rst), .bus(dbus));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.mem_rdata  <= DW'(bus.mem_addr);
    always @(posedge clk) dbus.mem_rdata <= DW'(dbus.mem_addr);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic checkw(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] exp_data(input int row, input int col);
        logic [N*DW-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++)
            for (int kr = 0; kr < K; kr++)
                for (int kc = 0; kc < K; kc++)
                    v[(c*K*K + kr*K + kc)*DW +: DW] = DW'(c*IMG_W*IMG_H + (row+kr)*IMG_W + col + kc);
        return v;
    endfunction

    // Ready driver: 0 = always ready, 1 = random, 2 = hold low 10 cycles on window (0,2).
    initial begin
        bus.win_ready  = 1'b1;
        dbus.win_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                1: bus.win_ready = 1'($urandom_range(0, 1));
                2: if (bus.win_valid && bus.win_row == 0 && bus.win_col == 2 && stall_cnt < 10) begin
                       bus.win_ready = 1'b0;
                       stall_cnt++;
                   end else bus.win_ready = 1'b1;
                default: bus.win_ready = 1'b1;
            endcase
        end
    end

    // Scoreboard: every valid cycle must show the next unaccepted window of the scan.
    initial begin
        int m_idx = 0, fetch_t = 0;
        bit prev_rd = 0, prev_vld = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_idx = 0; prev_rd = 0; prev_vld = 0;
            end else begin
                if (bus.start && !bus.busy && !bus.done) m_idx = 0;
                if (bus.mem_rd && !prev_rd) fetch_t = cyc;
                if (bus.mem_rd) check("no_fetch_during_out", bus.win_valid, 0);
                if (bus.win_valid) begin
                    if (!prev_vld) check("latency_fetch_to_valid", cyc - fetch_t, 19);
                    if (m_idx >= wr.size()) check("extra_window", m_idx, wr.size() - 1);
                    else begin
                        check("win_row", bus.win_row, wr[m_idx]);
                        check("win_col", bus.win_col, wc[m_idx]);
                        checkw("win_data", bus.win_data, exp_data(wr[m_idx], wc[m_idx]));
                        if (bus.win_ready) begin m_idx++; acc_cnt++; end
                    end
                end
                if (bus.done) begin
                    done_cnt++;
                    check("done_after_all_windows", m_idx, wr.size());
                    check("busy_low_at_done", bus.busy, 0);
                end
                prev_rd  = bus.mem_rd;
                prev_vld = bus.win_valid;
            end
        end
    end

    task automatic pulse_start;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int bound);
        for (int i = 0; i < bound && done_cnt == d0; i++) @(posedge clk);
        check("done_within_bound", done_cnt != d0, 1);
    endtask

    task automatic wait_first_valid;
        for (int i = 0; i < 100 && !bus.win_valid; i++) @(negedge clk);
        if (!bus.win_valid) @(negedge clk);
        check("first_valid_seen", bus.win_valid, 1);
        check("first_row", bus.win_row, 0);
        check("first_col", bus.win_col, 0);
        checkw("first_window_literal", bus.win_data, lit_v);
    endtask

    task automatic scan_end(input int d0, input int a0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("single_done_pulse", done_cnt - d0, 1);
        check("windows_accepted", acc_cnt - a0, 4);
        check("busy_low_after", bus.busy, 0);
    endtask

    task automatic check_reset_outputs;
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_win_valid", bus.win_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_win_row", bus.win_row, 0);
        check("rst_win_col", bus.win_col, 0);
        checkw("rst_win_data", bus.win_data, '0);
    endtask

    initial begin
        int d0, a0, ts, drd, ddn, dcyc, dbusy;
        rst = 1'b1;
        bus.start = 1'b0;
        dbus.start = 1'b0;
        for (int i = 0; i < N; i++) lit_v[i*DW +: DW] = DW'(lit00[i]);

        for (int r = 0; r + K <= IMG_H; r += STRIDE)
            for (int c = 0; c + K <= IMG_W; c += STRIDE) begin
                wr.push_back(r);
                wc.push_back(c);
            end
        // Pin the model against hand-computed values.
        check("model_count", wr.size(), 4);
        check("model_count_formula", wr.size(), ((IMG_W-K)/STRIDE+1)*((IMG_H-K)/STRIDE+1));
        check("model_w1_col", wc[1], 2);
        check("model_w2_row", wr[2], 2);
        check("model_w3_pos", {wr[3][15:0], wc[3][15:0]}, {16'd2, 16'd2});
        checkw("model_w00", exp_data(0, 0), lit_v);
        tmp_v = exp_data(2, 2);
        check("model_w22_e0", tmp_v[0 +: DW], 14);
        check("model_w22_e17", tmp_v[17*DW +: DW], 58);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        check("deg_rst_busy", dbus.busy, 0);
        check("deg_rst_mem_rd", dbus.mem_rd, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Straight scan, always ready.
        rmode = 0; d0 = done_cnt; a0 = acc_cnt;
        pulse_start();
        wait_first_valid();
        wait_done(d0, 500);
        scan_end(d0, a0);

        // Backpressure on window (0,2).
        rmode = 2; d0 = done_cnt; a0 = acc_cnt;
        pulse_start();
        wait_done(d0, 500);
        scan_end(d0, a0);
        check("stall_cycles", stall_cnt, 10);

        // Random ready with extra starts while busy.
        rmode = 1;
        for (int s = 0; s < 3; s++) begin
            d0 = done_cnt; a0 = acc_cnt;
            pulse_start();
            for (int i = 0; i < 2000 && done_cnt == d0; i++) begin
                @(posedge clk); #1;
                bus.start = bus.busy && ($urandom_range(0, 15) == 0);
            end
            bus.start = 1'b0;
            check("rand_scan_done", done_cnt != d0, 1);
            scan_end(d0, a0);
        end

        // Reset in the middle of fetching window (2,0).
        rmode = 0; a0 = acc_cnt;
        pulse_start();
        for (int i = 0; i < 500 && acc_cnt - a0 < 2; i++) @(posedge clk);
        for (int i = 0; i < 50 && !bus.mem_rd; i++) @(negedge clk);
        check("fetching_before_rst", bus.mem_rd, 1);
        check("fetch_row_2", bus.win_row, 2);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        d0 = done_cnt; a0 = acc_cnt;
        pulse_start();
        wait_first_valid();
        wait_done(d0, 500);
        scan_end(d0, a0);

        // Degenerate K=7 instance; second start lands while busy.
        drd = 0; ddn = 0; dcyc = -1; dbusy = 0;
        @(posedge clk); #1 dbus.start = 1'b1; ts = cyc;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dbus.mem_rd) drd++;
            if (dbus.done) begin ddn++; dcyc = cyc; end
            if (cyc == ts + 1) dbusy = dbus.busy;
            @(posedge clk); #1 dbus.start = (cyc == ts + 1);
        end
        dbus.start = 1'b0;
        check("deg_no_reads", drd, 0);
        check("deg_one_done", ddn, 1);
        check("deg_done_2_cycles", dcyc - ts, 2);
        check("deg_busy_after_start", dbusy, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
